// File: rtl/data_ram_if.sv
// Load/store request/response bus between the memory stage and data RAM.
// master: initiator (core), slave: responder (data_ram).
interface data_ram_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [2:0]  req_size_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i,
    output req_size_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i,
    input  req_size_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/data_ram.sv
// Data RAM responder: one B/H/W load or store at a time, fixed wait
// states, sign/zero-extended read data and an error flag.
// Ports: clk, rst_n (async, active-low), bus (data_ram_if.slave).
// Option: DATA_RAM_MISALIGN_CHK_EN flags misaligned/reserved accesses;
// without it addresses are force-aligned and reserved sizes act as W.
module data_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  data_ram_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access operands: straight from the bus when the access happens
  // on the accept edge (no wait states), else from the latches.
  logic          idle;
  logic [AW+1:0] a_addr;
  logic          a_we;
  logic [2:0]    a_size;
  logic [31:0]   a_wdata;

  logic          is_rsv, is_b, is_h;
  logic          a_err;
  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [31:0]   rshift;
  logic [31:0]   ld_val;
  logic          access;
  logic          mem_we;

  logic unused_addr;
  assign unused_addr = ^bus.req_addr_i[31:AW+2];

  assign idle    = (state_q == S_IDLE);
  assign a_addr  = idle ? bus.req_addr_i[AW+1:0] : addr_q;
  assign a_we    = idle ? bus.req_we_i : we_q;
  assign a_size  = idle ? bus.req_size_i : size_q;
  assign a_wdata = idle ? bus.req_wdata_i : wdata_q;

  always_comb begin
    is_rsv = (a_size == 3'b011) | (a_size == 3'b110) |
             (a_size == 3'b111) | (a_we & a_size[2]);
    is_b = ~is_rsv & (a_size[1:0] == 2'b00);
    is_h = ~is_rsv & (a_size[1:0] == 2'b01);
`ifdef DATA_RAM_MISALIGN_CHK_EN
    a_err = is_rsv | (is_h & a_addr[0]) |
            (~is_b & ~is_h & (a_addr[1:0] != 2'b00));
    off = a_addr[1:0];
`else
    a_err = 1'b0;
    off = is_b ? a_addr[1:0] :
          is_h ? {a_addr[1], 1'b0} : 2'b00;
`endif
  end

  assign idx = a_addr[AW+1:2];

  always_comb begin
    be   = 4'b1111;
    wrep = a_wdata;
    if (is_b) begin
      be   = 4'b0001 << off;
      wrep = {4{a_wdata[7:0]}};
    end else if (is_h) begin
      be   = off[1] ? 4'b1100 : 4'b0011;
      wrep = {2{a_wdata[15:0]}};
    end
  end

  always_comb begin
    rshift = mem[idx] >> {off, 3'b000};
    ld_val = rshift;
    if (is_b)
      ld_val = {{24{rshift[7] & ~a_size[2]}}, rshift[7:0]};
    else if (is_h)
      ld_val = {{16{rshift[15] & ~a_size[2]}}, rshift[15:0]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i[AW+1:0];
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          wdata_d = bus.req_wdata_i;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      (state_q == S_WAIT): begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      (state_q == S_RESP): begin
        if (bus.rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (access) begin
      err_d   = a_err;
      rdata_d = (a_err | a_we) ? 32'd0 : ld_val;
    end
  end

  // Gate with rst_n so nothing commits on an edge while reset is held.
  assign mem_we = access & a_we & ~a_err & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  assign bus.req_ready_o = idle;
  assign bus.rsp_valid_o = (state_q == S_RESP);
  assign bus.rsp_rdata_o = rdata_q;
`ifdef DATA_RAM_MISALIGN_CHK_EN
  assign bus.rsp_err_o = err_q;
`else
  assign bus.rsp_err_o = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: store/load, sub-word access,
// backpressure, misalignment, reserved sizes, reset mid-transaction.
module tb_data_ram;

  localparam int DEPTH = 1024;
  localparam int WAITC = 1;
  localparam int LAT   = WAITC + 1;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  data_ram_if bus ();

  data_ram #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one transaction with rsp_ready_i=1; returns response and
  // latency counted in edges from (and including) the accept edge.
  task automatic txn(input logic we, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_size_i  = sz;
    bus.req_addr_i  = a;
    bus.req_wdata_i = wd;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.rsp_rdata_o;
    er = bus.rsp_err_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_size_i  = 3'b0;
    bus.req_addr_i  = 32'd0;
    bus.req_wdata_i = 32'd0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o} !== 3'b100
        || bus.rsp_rdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/vld/err=%b%b%b rdata=%h want 100/0",
               bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
               bus.rsp_rdata_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_checks++;
    if (lat !== LAT || er !== 1'b0 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_0x10: lat=%0d err=%b rd=%h want %0d/0/0",
               lat, er, rd, LAT);
    end
    txn(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (lat !== LAT || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_0x10: lat=%0d err=%b rd=%h want %0d/0/deadbeef",
               lat, er, rd, LAT);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b0, SZ_B, 32'h13, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFFDE || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_0x13: got %h err=%b want ffffffde", rd, er);
    end
    txn(1'b0, SZ_BU, 32'h13, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h000000DE || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lbu_0x13: got %h err=%b want 000000de", rd, er);
    end
    txn(1'b0, SZ_H, 32'h12, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lh_0x12: got %h err=%b want ffffdead", rd, er);
    end
    txn(1'b0, SZ_HU, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0000BEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu_0x10: got %h err=%b want 0000beef", rd, er);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, SZ_B, 32'h11, 32'hAABBCC55, rd, er, lat);
    txn(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_lanes: got %h want dead55ef", rd);
    end
    txn(1'b0, SZ_B, 32'h11, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000055) begin
      n_fail++;
      $display("FAIL lb_pos_0x11: got %h want 00000055", rd);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_size_i  = SZ_W;
    bus.req_addr_i  = 32'h10;
    bus.rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    // Competing store presented while busy; must never be taken.
    bus.req_we_i    = 1'b1;
    bus.req_wdata_i = 32'h0;
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want %0d", lat, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0 ||
          bus.rsp_rdata_o !== 32'hDEAD55EF || bus.rsp_err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b rd=%h want 1/0/dead55ef",
                 i, bus.rsp_valid_o, bus.req_ready_o, bus.rsp_rdata_o);
      end
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0/1",
               bus.rsp_valid_o, bus.req_ready_o);
    end
    bus.req_valid_i = 1'b0;
    begin
      logic [31:0] rd;
      logic er;
      txn(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hDEAD55EF) begin
        n_fail++;
        $display("FAIL bp_no_accept: got %h want dead55ef", rd);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic er;
    int lat;
    logic [31:0] exp_w;
    logic        exp_e;
    logic [31:0] exp_h;
    txn(1'b1, SZ_W, 32'h20, 32'hA5A5A5A5, rd, er, lat);
    txn(1'b1, SZ_W, 32'h22, 32'h12345678, rd, er, lat);
`ifdef DATA_RAM_MISALIGN_CHK_EN
    exp_e = 1'b1;
    exp_w = 32'hA5A5A5A5;
    exp_h = 32'h0;
`else
    exp_e = 1'b0;
    exp_w = 32'h12345678;
    exp_h = 32'h000055EF;
`endif
    n_checks++;
    if (er !== exp_e || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_0x22_err: err=%b rd=%h want %b/0", er, rd, exp_e);
    end
    txn(1'b0, SZ_W, 32'h20, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== exp_w || er !== 1'b0) begin
      n_fail++;
      $display("FAIL word_0x20: got %h want %h", rd, exp_w);
    end
    txn(1'b0, SZ_H, 32'h11, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== exp_h || er !== exp_e) begin
      n_fail++;
      $display("FAIL lh_0x11: got %h err=%b want %h/%b",
               rd, er, exp_h, exp_e);
    end
  endtask

  task automatic test_reserved();
    logic [31:0] rd;
    logic er;
    int lat;
    logic [31:0] exp_r;
    logic        exp_e;
`ifdef DATA_RAM_MISALIGN_CHK_EN
    exp_r = 32'h0;
    exp_e = 1'b1;
`else
    exp_r = 32'hDEAD55EF;
    exp_e = 1'b0;
`endif
    txn(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== exp_r || er !== exp_e) begin
      n_fail++;
      $display("FAIL rsv_011: got %h err=%b want %h/%b",
               rd, er, exp_r, exp_e);
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] rd;
    logic er;
    int lat;
    txn(1'b1, SZ_W, 32'h30, 32'h11112222, rd, er, lat);
    txn(1'b0, SZ_W, 32'h30, 32'h0, rd, er, lat);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_size_i  = SZ_W;
    bus.req_addr_i  = 32'h30;
    bus.req_wdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    n_checks++;
    if (bus.req_ready_o !== 1'b0 || bus.rsp_rdata_o !== 32'h11112222) begin
      n_fail++;
      $display("FAIL in_wait: rdy=%b rd=%h want 0/11112222",
               bus.req_ready_o, bus.rsp_rdata_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o} !== 3'b100
        || bus.rsp_rdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: rdy/vld/err=%b%b%b rd=%h want 100/0",
               bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
               bus.rsp_rdata_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, SZ_W, 32'h30, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11112222 || lat !== LAT) begin
      n_fail++;
      $display("FAIL discard_store: got %h lat=%0d want 11112222/%0d",
               rd, lat, LAT);
    end
    txn(1'b0, SZ_W, 32'h30 + DEPTH * 4, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11112222) begin
      n_fail++;
      $display("FAIL alias_read: got %h want 11112222", rd);
    end
    txn(1'b1, SZ_W, 32'h30 + DEPTH * 4, 32'h0BADF00D, rd, er, lat);
    txn(1'b0, SZ_W, 32'h30, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL alias_write: got %h want 0badf00d", rd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_store_load();
    test_subword();
    test_byte_store();
    test_backpressure();
    test_misalign();
    test_reserved();
    test_reset_mid_txn();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
